alu_issue_ctrl: RTL and testbench
=================================

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 Parameters: none; widths SHALL come from `DATA_INDEX_LIMIT (31, data) and `ALU_OPRN_INDEX_LIMIT (5, opcode) in prj_definition.v.
REQ-002 CLK  input  1  clock; all state SHALL update on the rising edge.
REQ-003 RST  input  1  reset; asynchronous, active-low.
REQ-004 REQ_VALID  input  1  operation request valid.
REQ-005 REQ_READY  output  1  block can accept a request.
REQ-006 REQ_OPRN  input  6  ALU operation code.
REQ-007 REQ_RS1, REQ_RS2, REQ_RD  input  5 each  source-1, source-2 and destination register addresses.
REQ-008 REQ_IMM_SEL  input  1  use immediate as operand 2.
REQ-009 REQ_IMM  input  16  immediate value, sign-extended.
REQ-010 LOAD_EN  input  1  preload strobe.
REQ-011 LOAD_ADDR  input  5  preload register address.
REQ-012 LOAD_DATA  input  32  preload data.
REQ-013 ALU_OP1, ALU_OP2  output  32 each  operands driven to the downstream ALU.
REQ-014 ALU_OPRN  output  6  opcode driven to the downstream ALU.
REQ-015 ALU_OUT  input  32  ALU result.
REQ-016 ALU_ZERO  input  1  ALU zero flag.
REQ-017 DONE  output  1  one-cycle completion pulse.
REQ-018 RESULT  output  32  captured result.
REQ-019 ZERO_OUT  output  1  captured zero flag.

Function
REQ-020 Register file SHALL hold 32 x 32-bit registers; R0 SHALL read 0, and writes to R0 SHALL be ignored.
REQ-021 FSM SHALL have states IDLE, FETCH, EXEC, WB, with transitions IDLE->FETCH on REQ_VALID&REQ_READY, FETCH->EXEC, EXEC->WB and WB->IDLE unconditionally.
REQ-022 REQ_READY SHALL be 1 only in IDLE.
REQ-023 On accept, REQ_OPRN/RS1/RS2/RD/IMM_SEL/IMM SHALL be latched; later request-input changes SHALL have no effect.
REQ-024 At the FETCH->EXEC edge, ALU_OP1, ALU_OP2 and ALU_OPRN registers SHALL load the operands and latched opcode, and SHALL hold until the next FETCH.
REQ-025 At the EXEC->WB edge, RESULT and ZERO_OUT SHALL capture ALU_OUT and ALU_ZERO.
REQ-026 DONE SHALL be 1 exactly while in WB.
REQ-027 At the WB->IDLE edge, RESULT SHALL be written to RD (dropped when RD=0).
REQ-028 Latency: DONE SHALL assert in the cycle beginning 3 edges after accept, and the next accept SHALL be possible 4 edges after the previous one.
REQ-029 RS equal to the previous RD SHALL read the written value, since the write precedes the next FETCH.
REQ-030 LOAD_EN SHALL write LOAD_DATA to LOAD_ADDR only in IDLE; it SHALL be ignored in other states.
REQ-031 LOAD_EN and an accept in the same IDLE cycle SHALL both take effect; a source matching LOAD_ADDR SHALL receive LOAD_DATA.

Reset
REQ-032 Reset assertion SHALL force IDLE, REQ_READY=1 and DONE=0, and SHALL zero ALU_OP1, ALU_OP2, ALU_OPRN, RESULT, ZERO_OUT and all registers.
REQ-033 Reset mid-operation SHALL abort the operation with no write-back.

Configuration
REQ-034 With ALU_ISSUE_IMM_EN defined and REQ_IMM_SEL=1, ALU_OP2 SHALL be sign-extended REQ_IMM instead of register RS2.
REQ-035 Without ALU_ISSUE_IMM_EN, REQ_IMM_SEL and REQ_IMM SHALL be ignored and ALU_OP2 SHALL always be RS2; ports SHALL remain present.

Structure
REQ-036 FSM state encodings, register-address width (5) and immediate width (16) SHALL be defined in prj_definition.v.
REQ-037 The register file SHALL be a sub-module alu_regfile with 2 read ports and 1 write port, with write-vs-load muxing in alu_issue_ctrl.

Verification
REQ-038 Bench SHALL couple the block to the ALU model (OPRN 1=add, 2=sub) and cover these directed scenarios:
- Preload R1=2, R2=1; request sub RS1=1 RS2=2 RD=3 -> DONE 3 edges after accept; RESULT=1; ZERO_OUT=0; R3=1.
- Preload R4=100, R5=79; sub RD=6; then add RS1=6 RS2=6 RD=7 -> R7=42; second REQ_READY rises 4 edges after first accept.
- Preload R8=-12 (0xFFFFFFF4), R9=15; add RD=0 -> RESULT=3; R0 still reads 0.
- Sub R2-R2 -> ZERO_OUT=1, RESULT=0.
- RST low during EXEC -> IDLE, outputs 0, RD unchanged.
- With ALU_ISSUE_IMM_EN: R10=10, IMM=0xFFFD, IMM_SEL=1, add -> RESULT=7; without the macro -> RESULT=10+R[RS2].

Source files
------------

// File: rtl/alu_issue_ctrl_pkg.sv
// Project-wide widths, FSM encodings and helpers for the ALU issue controller.
// Optional immediate operand path is enabled by defining ALU_ISSUE_IMM_EN.
`ifndef DATA_INDEX_LIMIT
`define DATA_INDEX_LIMIT 31
`endif
`ifndef ALU_OPRN_INDEX_LIMIT
`define ALU_OPRN_INDEX_LIMIT 5
`endif
`ifndef REG_ADDR_INDEX_LIMIT
`define REG_ADDR_INDEX_LIMIT 4
`endif
`ifndef IMM_INDEX_LIMIT
`define IMM_INDEX_LIMIT 15
`endif
`ifndef STATE_IDLE
`define STATE_IDLE 2'b00
`define STATE_FETCH 2'b01
`define STATE_EXEC 2'b10
`define STATE_WB 2'b11
`endif

package alu_issue_ctrl_pkg;

  localparam int DW   = `DATA_INDEX_LIMIT + 1;
  localparam int OW   = `ALU_OPRN_INDEX_LIMIT + 1;
  localparam int AW   = `REG_ADDR_INDEX_LIMIT + 1;
  localparam int IW   = `IMM_INDEX_LIMIT + 1;
  localparam int NREG = 1 << AW;

  typedef enum logic [1:0] {
    ST_IDLE  = `STATE_IDLE,
    ST_FETCH = `STATE_FETCH,
    ST_EXEC  = `STATE_EXEC,
    ST_WB    = `STATE_WB
  } state_e;

  function automatic logic [DW-1:0] sext_imm(
    input logic [IW-1:0] imm
  );
    return {{(DW-IW){imm[IW-1]}}, imm};
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// 32-entry register file: two async read ports, one write port.
// Entry 0 is hardwired to zero.
module alu_regfile
  import alu_issue_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr1_i,
  output logic [DW-1:0] rdata1_o,
  input  logic [AW-1:0] raddr2_i,
  output logic [DW-1:0] rdata2_o
);

  logic [DW-1:0] mem_q [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = (raddr1_i == '0) ? '0 : mem_q[raddr1_i];
  assign rdata2_o = (raddr2_i == '0) ? '0 : mem_q[raddr2_i];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller: latches a request, fetches operands, drives the ALU,
// captures the result and writes it back. Define ALU_ISSUE_IMM_EN for imm op2.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
(
  input  logic          CLK,
  input  logic          RST,
  input  logic          REQ_VALID,
  output logic          REQ_READY,
  input  logic [OW-1:0] REQ_OPRN,
  input  logic [AW-1:0] REQ_RS1,
  input  logic [AW-1:0] REQ_RS2,
  input  logic [AW-1:0] REQ_RD,
  input  logic          REQ_IMM_SEL,
  input  logic [IW-1:0] REQ_IMM,
  input  logic          LOAD_EN,
  input  logic [AW-1:0] LOAD_ADDR,
  input  logic [DW-1:0] LOAD_DATA,
  output logic [DW-1:0] ALU_OP1,
  output logic [DW-1:0] ALU_OP2,
  output logic [OW-1:0] ALU_OPRN,
  input  logic [DW-1:0] ALU_OUT,
  input  logic          ALU_ZERO,
  output logic          DONE,
  output logic [DW-1:0] RESULT,
  output logic          ZERO_OUT
);

  state_e        state_q, state_d;
  logic          accept;
  logic [OW-1:0] oprn_q;
  logic [AW-1:0] rs1_q, rs2_q, rd_q;
  logic [DW-1:0] op1_q, op2_q;
  logic [OW-1:0] aoprn_q;
  logic [DW-1:0] result_q;
  logic          zero_q;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [DW-1:0] rd1, rd2;
  logic [DW-1:0] op2_src;
  logic          wb_sel, ld_sel;

  assign REQ_READY = (state_q == ST_IDLE);
  assign DONE      = (state_q == ST_WB);
  assign accept    = REQ_VALID & REQ_READY;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept) state_d = ST_FETCH;
      ST_FETCH: state_d = ST_EXEC;
      ST_EXEC:  state_d = ST_WB;
      ST_WB:    state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      oprn_q <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
      rd_q   <= '0;
    end else if (accept) begin
      oprn_q <= REQ_OPRN;
      rs1_q  <= REQ_RS1;
      rs2_q  <= REQ_RS2;
      rd_q   <= REQ_RD;
    end
  end

`ifdef ALU_ISSUE_IMM_EN
  logic          imm_sel_q;
  logic [IW-1:0] imm_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      imm_sel_q <= 1'b0;
      imm_q     <= '0;
    end else if (accept) begin
      imm_sel_q <= REQ_IMM_SEL;
      imm_q     <= REQ_IMM;
    end
  end

  assign op2_src = imm_sel_q ? sext_imm(imm_q) : rd2;
`else
  logic unused_imm;
  assign unused_imm = ^{REQ_IMM_SEL, REQ_IMM};
  assign op2_src    = rd2;
`endif

  // Operands hold from EXEC until the next FETCH completes.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      op1_q   <= '0;
      op2_q   <= '0;
      aoprn_q <= '0;
    end else if (state_q == ST_FETCH) begin
      op1_q   <= rd1;
      op2_q   <= op2_src;
      aoprn_q <= oprn_q;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      result_q <= '0;
      zero_q   <= 1'b0;
    end else if (state_q == ST_EXEC) begin
      result_q <= ALU_OUT;
      zero_q   <= ALU_ZERO;
    end
  end

  assign ALU_OP1  = op1_q;
  assign ALU_OP2  = op2_q;
  assign ALU_OPRN = aoprn_q;
  assign RESULT   = result_q;
  assign ZERO_OUT = zero_q;

  assign wb_sel = (state_q == ST_WB);
  assign ld_sel = (state_q == ST_IDLE) & LOAD_EN;

  // Write-back and preload live in disjoint states, so one port suffices.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    unique case (1'b1)
      wb_sel: begin
        rf_we    = 1'b1;
        rf_waddr = rd_q;
        rf_wdata = result_q;
      end
      ld_sel: begin
        rf_we    = 1'b1;
        rf_waddr = LOAD_ADDR;
        rf_wdata = LOAD_DATA;
      end
      default: ;
    endcase
  end

  alu_regfile u_rf (
    .clk      (CLK),
    .rst_n    (RST),
    .we_i     (rf_we),
    .waddr_i  (rf_waddr),
    .wdata_i  (rf_wdata),
    .raddr1_i (rs1_q),
    .rdata1_o (rd1),
    .raddr2_i (rs2_q),
    .rdata2_o (rd2)
  );

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl coupled to a tiny add/sub ALU model.
// Immediate expectations follow ALU_ISSUE_IMM_EN.
module tb_alu_issue_ctrl;
  import alu_issue_ctrl_pkg::*;

  logic          CLK = 1'b0;
  logic          RST;
  logic          REQ_VALID;
  logic          REQ_READY;
  logic [OW-1:0] REQ_OPRN;
  logic [AW-1:0] REQ_RS1, REQ_RS2, REQ_RD;
  logic          REQ_IMM_SEL;
  logic [IW-1:0] REQ_IMM;
  logic          LOAD_EN;
  logic [AW-1:0] LOAD_ADDR;
  logic [DW-1:0] LOAD_DATA;
  logic [DW-1:0] ALU_OP1, ALU_OP2;
  logic [OW-1:0] ALU_OPRN;
  logic [DW-1:0] ALU_OUT;
  logic          ALU_ZERO;
  logic          DONE;
  logic [DW-1:0] RESULT;
  logic          ZERO_OUT;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  always_comb begin
    ALU_OUT = '0;
    if (ALU_OPRN == 6'd1)      ALU_OUT = ALU_OP1 + ALU_OP2;
    else if (ALU_OPRN == 6'd2) ALU_OUT = ALU_OP1 - ALU_OP2;
    ALU_ZERO = (ALU_OUT == '0);
  end

  alu_issue_ctrl dut (
    .CLK         (CLK),
    .RST         (RST),
    .REQ_VALID   (REQ_VALID),
    .REQ_READY   (REQ_READY),
    .REQ_OPRN    (REQ_OPRN),
    .REQ_RS1     (REQ_RS1),
    .REQ_RS2     (REQ_RS2),
    .REQ_RD      (REQ_RD),
    .REQ_IMM_SEL (REQ_IMM_SEL),
    .REQ_IMM     (REQ_IMM),
    .LOAD_EN     (LOAD_EN),
    .LOAD_ADDR   (LOAD_ADDR),
    .LOAD_DATA   (LOAD_DATA),
    .ALU_OP1     (ALU_OP1),
    .ALU_OP2     (ALU_OP2),
    .ALU_OPRN    (ALU_OPRN),
    .ALU_OUT     (ALU_OUT),
    .ALU_ZERO    (ALU_ZERO),
    .DONE        (DONE),
    .RESULT      (RESULT),
    .ZERO_OUT    (ZERO_OUT)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [4:0] a, input logic [31:0] d);
    @(negedge CLK);
    LOAD_EN   = 1'b1;
    LOAD_ADDR = a;
    LOAD_DATA = d;
    @(negedge CLK);
    LOAD_EN   = 1'b0;
  endtask

  // One full request; inputs are scrambled after accept and a stray
  // preload is held outside IDLE, both of which must be ignored.
  task automatic run_op(
    input string tag, input logic [5:0] op,
    input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
    input logic isel, input logic [15:0] imm,
    input logic ld, input logic [4:0] la, input logic [31:0] ldd,
    input logic [31:0] e1, input logic [31:0] e2,
    input logic [31:0] er, input logic ez);
    @(negedge CLK);
    chk({tag, "_ready_idle"}, {31'd0, REQ_READY}, 32'd1);
    REQ_VALID   = 1'b1;
    REQ_OPRN    = op;
    REQ_RS1     = rs1;
    REQ_RS2     = rs2;
    REQ_RD      = rd;
    REQ_IMM_SEL = isel;
    REQ_IMM     = imm;
    LOAD_EN     = ld;
    LOAD_ADDR   = la;
    LOAD_DATA   = ldd;
    @(negedge CLK);
    REQ_VALID   = 1'b0;
    REQ_OPRN    = 6'h3F;
    REQ_RS1     = ~rs1;
    REQ_RS2     = ~rs2;
    REQ_RD      = ~rd;
    REQ_IMM_SEL = ~isel;
    REQ_IMM     = ~imm;
    LOAD_EN     = 1'b1;
    LOAD_ADDR   = 5'd11;
    LOAD_DATA   = 32'hDEADBEEF;
    chk({tag, "_ready_fetch"}, {31'd0, REQ_READY}, 32'd0);
    @(negedge CLK);
    chk({tag, "_done_exec"}, {31'd0, DONE}, 32'd0);
    chk({tag, "_op1"}, ALU_OP1, e1);
    chk({tag, "_op2"}, ALU_OP2, e2);
    chk({tag, "_oprn"}, {26'd0, ALU_OPRN}, {26'd0, op});
    @(negedge CLK);
    chk({tag, "_done_wb"}, {31'd0, DONE}, 32'd1);
    chk({tag, "_result"}, RESULT, er);
    chk({tag, "_zero"}, {31'd0, ZERO_OUT}, {31'd0, ez});
    @(negedge CLK);
    chk({tag, "_ready_back"}, {31'd0, REQ_READY}, 32'd1);
    chk({tag, "_done_clr"}, {31'd0, DONE}, 32'd0);
    LOAD_EN = 1'b0;
  endtask

  task automatic read_reg(input string tag, input logic [4:0] a,
                          input logic [31:0] v);
    run_op(tag, 6'd1, a, 5'd0, 5'd0, 1'b0, 16'd0, 1'b0, 5'd0, 32'd0,
           v, 32'd0, v, (v == 32'd0));
  endtask

  initial begin
    #50000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    RST = 1'b0;
    REQ_VALID = 1'b0;
    REQ_OPRN = '0;
    REQ_RS1 = '0;
    REQ_RS2 = '0;
    REQ_RD = '0;
    REQ_IMM_SEL = 1'b0;
    REQ_IMM = '0;
    LOAD_EN = 1'b0;
    LOAD_ADDR = '0;
    LOAD_DATA = '0;
    @(negedge CLK);
    @(negedge CLK);
    chk("rst_ready", {31'd0, REQ_READY}, 32'd1);
    chk("rst_done", {31'd0, DONE}, 32'd0);
    chk("rst_op1", ALU_OP1, 32'd0);
    chk("rst_op2", ALU_OP2, 32'd0);
    chk("rst_oprn", {26'd0, ALU_OPRN}, 32'd0);
    chk("rst_result", RESULT, 32'd0);
    chk("rst_zero", {31'd0, ZERO_OUT}, 32'd0);
    RST = 1'b1;

    load(5'd1, 32'd2);
    load(5'd2, 32'd1);
    run_op("sub1", 6'd2, 5'd1, 5'd2, 5'd3, 1'b0, 16'd0, 1'b0, 5'd0, 32'd0,
           32'd2, 32'd1, 32'd1, 1'b0);
    read_reg("r3", 5'd3, 32'd1);

    load(5'd4, 32'd100);
    load(5'd5, 32'd79);
    run_op("sub2", 6'd2, 5'd4, 5'd5, 5'd6, 1'b0, 16'd0, 1'b0, 5'd0, 32'd0,
           32'd100, 32'd79, 32'd21, 1'b0);
    run_op("fwd", 6'd1, 5'd6, 5'd6, 5'd7, 1'b0, 16'd0, 1'b0, 5'd0, 32'd0,
           32'd21, 32'd21, 32'd42, 1'b0);
    read_reg("r7", 5'd7, 32'd42);
    @(negedge CLK);
    chk("op1_hold", ALU_OP1, 32'd42);

    load(5'd8, 32'hFFFFFFF4);
    load(5'd9, 32'd15);
    run_op("neg_rd0", 6'd1, 5'd8, 5'd9, 5'd0, 1'b0, 16'd0, 1'b0, 5'd0,
           32'd0, 32'hFFFFFFF4, 32'd15, 32'd3, 1'b0);
    load(5'd0, 32'd5);
    run_op("r0_zero", 6'd1, 5'd0, 5'd9, 5'd0, 1'b0, 16'd0, 1'b0, 5'd0,
           32'd0, 32'd0, 32'd15, 32'd15, 1'b0);

    run_op("zero", 6'd2, 5'd2, 5'd2, 5'd0, 1'b0, 16'd0, 1'b0, 5'd0, 32'd0,
           32'd1, 32'd1, 32'd0, 1'b1);
    read_reg("r11_noload", 5'd11, 32'd0);

    run_op("ld_acc", 6'd1, 5'd12, 5'd1, 5'd13, 1'b0, 16'd0, 1'b1, 5'd12,
           32'h55, 32'h55, 32'd2, 32'h57, 1'b0);
    read_reg("r13", 5'd13, 32'h57);

    @(negedge CLK);
    REQ_VALID = 1'b1;
    REQ_OPRN  = 6'd1;
    REQ_RS1   = 5'd1;
    REQ_RS2   = 5'd2;
    REQ_RD    = 5'd3;
    @(negedge CLK);
    REQ_VALID = 1'b0;
    @(negedge CLK);
    chk("abort_in_exec", {31'd0, DONE}, 32'd0);
    RST = 1'b0;
    #1;
    chk("abort_ready", {31'd0, REQ_READY}, 32'd1);
    chk("abort_done", {31'd0, DONE}, 32'd0);
    chk("abort_op1", ALU_OP1, 32'd0);
    chk("abort_op2", ALU_OP2, 32'd0);
    chk("abort_oprn", {26'd0, ALU_OPRN}, 32'd0);
    chk("abort_result", RESULT, 32'd0);
    chk("abort_zero", {31'd0, ZERO_OUT}, 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    chk("abort_no_done", {31'd0, DONE}, 32'd0);
    read_reg("r3_abort", 5'd3, 32'd0);
    read_reg("r1_abort", 5'd1, 32'd0);

    load(5'd10, 32'd10);
    load(5'd15, 32'd6);
`ifdef ALU_ISSUE_IMM_EN
    run_op("imm", 6'd1, 5'd10, 5'd15, 5'd16, 1'b1, 16'hFFFD, 1'b0, 5'd0,
           32'd0, 32'd10, 32'hFFFFFFFD, 32'd7, 1'b0);
    read_reg("r16", 5'd16, 32'd7);
`else
    run_op("imm", 6'd1, 5'd10, 5'd15, 5'd16, 1'b1, 16'hFFFD, 1'b0, 5'd0,
           32'd0, 32'd10, 32'd6, 32'd16, 1'b0);
    read_reg("r16", 5'd16, 32'd16);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
